// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries local-predictor fetch metadata through the F->D->E
// pipeline registers. It issues an early redirect for predicted-taken branches in D
// and resolves branches in E. Each branch trains the predictor exactly once, and a
// misprediction produces a redirect PC. Two performance counters track resolved and
// mispredicted branches.
module branch_resolve_unit #(
  parameter int PHT_INDEX_BITS = 7,
  parameter int BHT_INDEX_BITS = 3,
  parameter int CNT_BITS       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stallD,
  input  logic                      flushD,
  input  logic                      stallE,
  input  logic                      flushE,
  input  logic [31:0]               pcF,
  input  logic                      predict_takeF,
  input  logic [BHT_INDEX_BITS-1:0] pc_hashingF,
  input  logic [PHT_INDEX_BITS-1:0] PHT_indexF,
  input  logic                      branchD,
  input  logic [31:0]               branch_targetD,
  input  logic                      actually_takenE,
  output logic                      pred_redirectD,
  output logic                      branchE,
  output logic [BHT_INDEX_BITS-1:0] BHT_indexE,
  output logic [PHT_INDEX_BITS-1:0] PHT_indexE,
  output logic                      predict_resultE,
  output logic                      mispredictE,
  output logic [31:0]               redirect_pcE,
  output logic [CNT_BITS-1:0]       br_count,
  output logic [CNT_BITS-1:0]       mispred_count,
  input  logic                      cnt_clear
);

  // F->D stage register
  logic                      validD_q;
  logic [31:0]               pcD_q;
  logic                      predD_q;
  logic [BHT_INDEX_BITS-1:0] bhtD_q;
  logic [PHT_INDEX_BITS-1:0] phtD_q;

  // D->E stage register
  logic                      validE_q;
  logic [31:0]               pcE_q;
  logic                      predE_q;
  logic [BHT_INDEX_BITS-1:0] bhtE_q;
  logic [PHT_INDEX_BITS-1:0] phtE_q;
  logic [31:0]               targetE_q;
  logic                      isbrE_q;

  // Set once the branch held in E has trained the predictor.
  // It suppresses repeat strobes while E is stalled.
  logic                      doneE_q, doneE_d;

  logic [CNT_BITS-1:0]       br_count_q, br_count_d;
  logic [CNT_BITS-1:0]       mispred_count_q, mispred_count_d;

  logic                      fire;
  logic                      mispredict;

  // F->D register: flush invalidates, stall holds, otherwise capture fetch metadata
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validD_q <= 1'b0;
      pcD_q    <= '0;
      predD_q  <= 1'b0;
      bhtD_q   <= '0;
      phtD_q   <= '0;
    end else if (flushD) begin
      validD_q <= 1'b0;
    end else if (!stallD) begin
      validD_q <= 1'b1;
      pcD_q    <= pcF;
      predD_q  <= predict_takeF;
      bhtD_q   <= pc_hashingF;
      phtD_q   <= PHT_indexF;
    end
  end

  // D->E register: flush beats stall; a load tags the entry as a branch only if D was valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validE_q  <= 1'b0;
      pcE_q     <= '0;
      predE_q   <= 1'b0;
      bhtE_q    <= '0;
      phtE_q    <= '0;
      targetE_q <= '0;
      isbrE_q   <= 1'b0;
    end else if (flushE) begin
      validE_q <= 1'b0;
    end else if (!stallE) begin
      validE_q  <= validD_q;
      pcE_q     <= pcD_q;
      predE_q   <= predD_q;
      bhtE_q    <= bhtD_q;
      phtE_q    <= phtD_q;
      targetE_q <= branch_targetD;
      isbrE_q   <= branchD & validD_q;
    end
  end

  // Resolution and next-state logic for the done flag and the counters
  always_comb begin
    fire       = validE_q & isbrE_q & ~doneE_q;
    mispredict = fire & (predE_q != actually_takenE);

    doneE_d = doneE_q;
    if (flushE || !stallE) begin
      doneE_d = 1'b0;
    end else if (fire) begin
      doneE_d = 1'b1;
    end

    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (cnt_clear) begin
      br_count_d      = '0;
      mispred_count_d = '0;
    end else begin
      if (fire)       br_count_d      = br_count_q + 1'b1;
      if (mispredict) mispred_count_d = mispred_count_q + 1'b1;
    end
  end

  // State update for the done flag and the performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      doneE_q         <= 1'b0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      doneE_q         <= doneE_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  // Output drive
  always_comb begin
    pred_redirectD  = validD_q & branchD & predD_q & ~flushD;
    branchE         = fire;
    mispredictE     = mispredict;
    predict_resultE = actually_takenE;
    BHT_indexE      = bhtE_q;
    PHT_indexE      = phtE_q;
    // The not-taken path skips the delay slot
    redirect_pcE    = '0;
    if (mispredict) begin
      redirect_pcE = actually_takenE ? targetE_q : (pcE_q + 32'd8);
    end
    br_count        = br_count_q;
    mispred_count   = mispred_count_q;
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit.
// A reference model tracks instruction tokens through D and E.
// Each occupancy of E gets a fresh id, and an id trains the predictor at most once.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallD, flushD, stallE, flushE;
  logic [31:0] pcF;
  logic        predict_takeF;
  logic [2:0]  pc_hashingF;
  logic [6:0]  PHT_indexF;
  logic        branchD;
  logic [31:0] branch_targetD;
  logic        actually_takenE;
  logic        pred_redirectD, branchE, predict_resultE, mispredictE;
  logic [2:0]  BHT_indexE;
  logic [6:0]  PHT_indexE;
  logic [31:0] redirect_pcE, br_count, mispred_count;
  logic        cnt_clear;

  int compares = 0;
  int fails    = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PHT_INDEX_BITS(7), .BHT_INDEX_BITS(3), .CNT_BITS(32)) dut (
    .clk(clk), .rst(rst),
    .stallD(stallD), .flushD(flushD), .stallE(stallE), .flushE(flushE),
    .pcF(pcF), .predict_takeF(predict_takeF), .pc_hashingF(pc_hashingF), .PHT_indexF(PHT_indexF),
    .branchD(branchD), .branch_targetD(branch_targetD), .actually_takenE(actually_takenE),
    .pred_redirectD(pred_redirectD), .branchE(branchE), .BHT_indexE(BHT_indexE),
    .PHT_indexE(PHT_indexE), .predict_resultE(predict_resultE), .mispredictE(mispredictE),
    .redirect_pcE(redirect_pcE), .br_count(br_count), .mispred_count(mispred_count),
    .cnt_clear(cnt_clear)
  );

  // Reference model state
  typedef struct {
    bit          v;
    int          eid;
    logic [31:0] pc;
    bit          pred;
    logic [2:0]  bht;
    logic [6:0]  pht;
    logic [31:0] target;
    bit          isbr;
  } tok_t;

  tok_t        mD, mE;
  bit          trained[int];
  int          next_eid = 1;
  logic [31:0] m_br, m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compares++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    mD = '{v: 0, eid: 0, pc: 0, pred: 0, bht: 0, pht: 0, target: 0, isbr: 0};
    mE = '{v: 0, eid: 0, pc: 0, pred: 0, bht: 0, pht: 0, target: 0, isbr: 0};
    trained.delete();
    m_br  = 0;
    m_mis = 0;
  endtask

  function automatic bit m_fire();
    return mE.v && mE.isbr && !trained.exists(mE.eid);
  endfunction

  // Compare every output against the model for the inputs currently applied
  task automatic check_all();
    bit          f, mp;
    logic [31:0] rpc;
    f   = m_fire();
    mp  = f && (mE.pred != actually_takenE);
    rpc = mp ? (actually_takenE ? mE.target : mE.pc + 32'd8) : 32'd0;
    chk("pred_redirectD", {31'd0, pred_redirectD}, {31'd0, mD.v & branchD & mD.pred & ~flushD});
    chk("branchE", {31'd0, branchE}, {31'd0, f});
    chk("mispredictE", {31'd0, mispredictE}, {31'd0, mp});
    chk("redirect_pcE", redirect_pcE, rpc);
    chk("predict_resultE", {31'd0, predict_resultE}, {31'd0, actually_takenE});
    chk("BHT_indexE", {29'd0, BHT_indexE}, {29'd0, mE.bht});
    chk("PHT_indexE", {25'd0, PHT_indexE}, {25'd0, mE.pht});
    chk("br_count", br_count, m_br);
    chk("mispred_count", mispred_count, m_mis);
  endtask

  // Apply inputs at the falling edge, then check the settled outputs
  task automatic drv(input bit sd, input bit fd, input bit se, input bit fe,
                     input logic [31:0] pc, input bit pr, input logic [2:0] bh,
                     input logic [6:0] ph, input bit br, input logic [31:0] tg,
                     input bit tk, input bit clr);
    @(negedge clk);
    rst = 1'b1;
    stallD = sd; flushD = fd; stallE = se; flushE = fe;
    pcF = pc; predict_takeF = pr; pc_hashingF = bh; PHT_indexF = ph;
    branchD = br; branch_targetD = tg; actually_takenE = tk; cnt_clear = clr;
    #1;
    check_all();
  endtask

  // Rising edge: advance the model with the inputs that were sampled
  task automatic tick();
    bit   f, mp;
    tok_t newE, newD;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      f  = m_fire();
      mp = f && (mE.pred != actually_takenE);
      if (f) trained[mE.eid] = 1'b1;
      if (cnt_clear) begin
        m_br = 0; m_mis = 0;
      end else begin
        if (f)  m_br  = m_br + 1;
        if (mp) m_mis = m_mis + 1;
      end
      newE = mE;
      if (flushE) newE.v = 0;
      else if (!stallE) begin
        newE        = mD;
        newE.eid    = next_eid++;
        newE.target = branch_targetD;
        newE.isbr   = branchD && mD.v;
      end
      newD = mD;
      if (flushD) newD.v = 0;
      else if (!stallD) begin
        newD.v = 1; newD.pc = pcF; newD.pred = predict_takeF;
        newD.bht = pc_hashingF; newD.pht = PHT_indexF;
      end
      mE = newE;
      mD = newD;
    end
    #1;
  endtask

  int pulses;

  initial begin
    rst = 1'b0;
    stallD = 0; flushD = 0; stallE = 0; flushE = 0;
    pcF = 0; predict_takeF = 0; pc_hashingF = 0; PHT_indexF = 0;
    branchD = 0; branch_targetD = 0; actually_takenE = 0; cnt_clear = 0;
    model_reset();
    #1;
    check_all();
    tick();
    check_all();

    // Predicted-taken branch that is actually taken
    drv(0,0,0,0, 32'h100, 1, 3'd5, 7'd77, 0, 32'h0, 0, 0); tick();
    drv(0,0,0,0, 32'h104, 0, 3'd1, 7'd1, 1, 32'h200, 0, 0);
    chk("t2_pred_redirectD", {31'd0, pred_redirectD}, 32'd1);
    tick();
    drv(0,0,0,0, 32'h108, 0, 3'd0, 7'd0, 0, 32'h0, 1, 0);
    chk("t2_branchE", {31'd0, branchE}, 32'd1);
    chk("t2_mispredictE", {31'd0, mispredictE}, 32'd0);
    chk("t2_BHT", {29'd0, BHT_indexE}, 32'd5);
    tick();
    chk("t2_br_count", br_count, 32'd1);

    // Predicted-taken branch that falls through
    drv(0,0,0,0, 32'h100, 1, 3'd2, 7'd9, 0, 32'h0, 0, 0); tick();
    drv(0,0,0,0, 32'h104, 0, 3'd0, 7'd0, 1, 32'h200, 0, 0); tick();
    drv(0,0,0,0, 32'h108, 0, 3'd0, 7'd0, 0, 32'h0, 0, 0);
    chk("t3_mispredictE", {31'd0, mispredictE}, 32'd1);
    chk("t3_redirect_pcE", redirect_pcE, 32'h108);
    tick();
    chk("t3_mispred_count", mispred_count, 32'd1);

    // Branch held in E for three stall cycles trains once
    drv(0,0,0,0, 32'h300, 0, 3'd3, 7'd3, 0, 32'h0, 0, 0); tick();
    drv(0,0,0,0, 32'h304, 0, 3'd0, 7'd0, 1, 32'h400, 0, 0); tick();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      drv(1,0,(i < 3),0, 32'h308, 0, 3'd0, 7'd0, 0, 32'h0, 0, 0);
      if (branchE) pulses++;
      tick();
    end
    chk("t4_pulses", pulses, 32'd1);
    chk("t4_br_count", br_count, 32'd3);

    // flushE together with stallE while a branch sits in D
    drv(0,0,0,0, 32'h500, 1, 3'd4, 7'd4, 0, 32'h0, 0, 0); tick();
    drv(0,0,1,1, 32'h504, 0, 3'd0, 7'd0, 1, 32'h600, 0, 0); tick();
    drv(1,0,1,0, 32'h504, 0, 3'd0, 7'd0, 1, 32'h600, 0, 0);
    chk("t5_branchE", {31'd0, branchE}, 32'd0);
    tick();

    // Reset asserted while a branch is in E
    drv(0,0,0,0, 32'h700, 0, 3'd6, 7'd6, 0, 32'h0, 0, 0); tick();
    drv(0,0,0,0, 32'h704, 0, 3'd0, 7'd0, 1, 32'h800, 0, 0); tick();
    drv(0,0,0,0, 32'h708, 0, 3'd0, 7'd0, 0, 32'h0, 0, 0);
    chk("t1_branchE_pre", {31'd0, branchE}, 32'd1);
    rst = 1'b0;
    actually_takenE = 0;
    #1;
    model_reset();
    check_all();
    chk("t1_branchE", {31'd0, branchE}, 32'd0);
    chk("t1_br_count", br_count, 32'd0);
    tick();
    check_all();

    // Wrap-around not-taken redirect with a counter clear on the same cycle
    drv(0,0,0,0, 32'hFFFF_FFFC, 1, 3'd7, 7'd127, 0, 32'h0, 0, 0); tick();
    drv(0,0,0,0, 32'h0, 0, 3'd0, 7'd0, 1, 32'h1000, 0, 0); tick();
    drv(0,0,0,0, 32'h4, 0, 3'd0, 7'd0, 0, 32'h0, 0, 1);
    chk("t6_redirect_pcE", redirect_pcE, 32'h4);
    chk("t6_branchE", {31'd0, branchE}, 32'd1);
    tick();
    chk("t6_br_count", br_count, 32'd0);
    chk("t6_mispred_count", mispred_count, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      drv(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC),
          $urandom_range(0, 1), 3'($urandom()), 7'($urandom()),
          ($urandom_range(0, 9) < 6), $urandom() & 32'hFFFF_FFFC,
          $urandom_range(0, 1), ($urandom_range(0, 29) == 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
